// File: rtl/seq_divider32_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   localparam int DIV_WIDTH = 32;

   // Every quotient bit is set when the divisor is zero.
   localparam logic DIV_ZERO_FILL = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2
   } div_state_t;

endpackage

// File: rtl/seq_divider32_if.sv
// Request/result bundle between the EX-stage controller (master) and the divider (slave).
interface seq_divider32_if #(
   parameter int WIDTH = div_pkg::DIV_WIDTH
) ();

   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_zero;

   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, done, quotient, remainder, div_zero
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, done, quotient, remainder, div_zero
   );

endinterface

// File: rtl/seq_divider32_sub_trial.sv
// Trial subtraction for one restoring-division step; borrow_out=1 means a < b.
module sub_trial
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   assign {borrow_out, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_divider32.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Signed operation (truncate toward zero) is compiled in only with DIV_SIGNED_EN defined.
//
// state | meaning
// IDLE  | waiting for start; results held
// CALC  | one shift/subtract per edge; a zero divisor finishes after a single edge
// FIXUP | applies quotient/remainder signs after a signed op
module seq_divider32
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic            clk,
   input  logic            rst_n,
   seq_divider32_if.slave  bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   div_state_t       state;
   div_state_t       state_nx;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dsr;
   logic             zero_op;
   logic             done_q;
   logic             div_zero_q;
   logic             busy_c;
   logic             finish_c;
   logic             fix_req;
   logic             last_iter;

   logic [WIDTH-1:0] rem_sh;
   logic [WIDTH-1:0] quo_sh;
   logic [WIDTH-1:0] trial;
   logic             borrow;

`ifdef DIV_SIGNED_EN
   logic             signed_op;
   logic             neg_q;
   logic             neg_r;
   assign fix_req = signed_op;
`else
   logic             unused_is_signed;
   assign unused_is_signed = bus.is_signed;
   assign fix_req = 1'b0;
`endif

   assign last_iter = (count == CW'(WIDTH - 1));
   assign rem_sh    = {rem[WIDTH-2:0], quo[WIDTH-1]};
   assign quo_sh    = {quo[WIDTH-2:0], 1'b0};

   sub_trial #(.WIDTH(WIDTH)) u_sub_trial (
      .a          (rem_sh),
      .b          (dsr),
      .diff       (trial),
      .borrow_out (borrow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = CALC;
         CALC: begin
            if (zero_op)        state_nx = IDLE;
            else if (last_iter) state_nx = fix_req ? FIXUP : IDLE;
         end
         FIXUP:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy_c   = (state != IDLE);
      finish_c = 1'b0;
      case (state)
         CALC:    finish_c = zero_op || (last_iter && !fix_req);
         FIXUP:   finish_c = 1'b1;
         default: finish_c = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count      <= '0;
         quo        <= '0;
         rem        <= '0;
         dsr        <= '0;
         zero_op    <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
         signed_op  <= 1'b0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
`endif
      end else begin
         done_q <= finish_c;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  count      <= '0;
                  rem        <= '0;
                  div_zero_q <= 1'b0;
                  zero_op    <= (bus.divisor == '0);
`ifdef DIV_SIGNED_EN
                  // Zero divisor keeps the raw dividend so it lands in the remainder untouched.
                  if (bus.is_signed && (bus.divisor != '0)) begin
                     quo       <= bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
                     dsr       <= bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
                     signed_op <= 1'b1;
                     neg_q     <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                     neg_r     <= bus.dividend[WIDTH-1];
                  end else begin
                     quo       <= bus.dividend;
                     dsr       <= bus.divisor;
                     signed_op <= 1'b0;
                     neg_q     <= 1'b0;
                     neg_r     <= 1'b0;
                  end
`else
                  quo <= bus.dividend;
                  dsr <= bus.divisor;
`endif
               end
            end
            CALC: begin
               if (zero_op) begin
                  quo        <= {WIDTH{DIV_ZERO_FILL}};
                  rem        <= quo;
                  div_zero_q <= 1'b1;
               end else begin
                  quo   <= {quo_sh[WIDTH-1:1], ~borrow};
                  rem   <= borrow ? rem_sh : trial;
                  count <= count + CW'(1);
               end
            end
            FIXUP: begin
`ifdef DIV_SIGNED_EN
               if (neg_q) quo <= -quo;
               if (neg_r) rem <= -rem;
`endif
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = busy_c;
   assign bus.done      = done_q;
   assign bus.quotient  = quo;
   assign bus.remainder = rem;
   assign bus.div_zero  = div_zero_q;

endmodule
